// File: rtl/dmem_pkg.sv
// Shared types and sizes for the data-memory responder.
package dmem_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned LANES      = 4;
  localparam int unsigned ADDR_W_DEF = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Overlay the enabled byte lanes of new_w onto old_w.
  function automatic logic [DATA_W-1:0] merge_lanes(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [LANES-1:0]  be
  );
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int b = 0; b < LANES; b++) begin
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed storage: byte-enabled synchronous write, combinational read,
// asynchronous clear, plus fixed taps on words 1..3.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              we,
  input  logic [LANES-1:0]  be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] ram1,
  output logic [DATA_W-1:0] ram2,
  output logic [DATA_W-1:0] ram3
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[ADDR_W'(i)] <= '0;
    end else if (we) begin
      for (int b = 0; b < LANES; b++) begin
        if (be[b]) mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem_q[addr];
  assign ram1  = mem_q[1];
  assign ram2  = mem_q[2];
  assign ram3  = mem_q[3];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with valid/ready handshakes.
// Optional response latency is enabled by defining DMEM_WAIT_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned ADDR_W      = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [LANES-1:0]  wr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [DATA_W-1:0] ram1,
  output logic [DATA_W-1:0] ram2,
  output logic [DATA_W-1:0] ram3
);

  state_e            state_q, state_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [DATA_W-1:0] rd_word;
  logic              accept;

`ifdef DMEM_WAIT_EN
  localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  logic unused_wait_cfg;
  assign unused_wait_cfg = (WAIT_CYCLES != 0);
`endif

  assign req_ready = (state_q == IDLE) && nrst;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

  dmem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk   (clk),
    .nrst  (nrst),
    .we    (accept),
    .be    (wr),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rd_word),
    .ram1  (ram1),
    .ram2  (ram2),
    .ram3  (ram3)
  );

  // Next-state and response register updates.
  always_comb begin
    state_d     = state_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
`ifdef DMEM_WAIT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          // Pre-write word merged with the store lanes equals the post-write word.
          rsp_data_d = merge_lanes(rd_word, wdata, wr);
`ifdef DMEM_WAIT_EN
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
            cnt_d   = CNT_W'(WAIT_CYCLES - 1);
          end else begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
          end
`else
          state_d     = RESP;
          rsp_valid_d = 1'b1;
`endif
        end
      end
`ifdef DMEM_WAIT_EN
      WAIT: begin
        if (cnt_q == '0) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`endif
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

`ifdef DMEM_WAIT_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder; honours DMEM_WAIT_EN for latency.
module tb_dmem_responder;

  localparam int unsigned AW = 6;
  localparam int unsigned WC = 2;
`ifdef DMEM_WAIT_EN
  localparam int LAT = WC + 1;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          nrst;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic [3:0]    wr;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_data;
  logic [31:0]   ram1, ram2, ram3;

  logic [31:0] model [64];
  logic [31:0] exp_q [$];
  int vectors = 0;
  int errors  = 0;

  dmem_responder #(.WAIT_CYCLES(WC), .ADDR_W(AW)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .addr      (addr),
    .wdata     (wdata),
    .wr        (wr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .ram1      (ram1),
    .ram2      (ram2),
    .ram3      (ram3)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Drive one request, push the expected word, return negedges until rsp_valid.
  task automatic send_req(input logic [AW-1:0] a, input logic [31:0] d,
                          input logic [3:0] be, output int lat);
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL req_ready_before_accept got %b want 1", req_ready);
    end
    req_valid = 1'b1; addr = a; wdata = d; wr = be;
    @(posedge clk);
    for (int b = 0; b < 4; b++) if (be[b]) model[a][8*b +: 8] = d[8*b +: 8];
    exp_q.push_back(model[a]);
    #1;
    req_valid = 1'b0; wr = 4'($urandom); wdata = $urandom; addr = AW'($urandom);
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (rsp_valid === 1'b1) break;
    end
  endtask

  // Consume the pending response at the current negedge and score it.
  task automatic pop_rsp(input string tag);
    logic [31:0] exp;
    vectors++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard_empty got %h", tag, rsp_data);
    end else begin
      exp = exp_q.pop_front();
      if (rsp_data !== exp) begin
        errors++;
        $display("FAIL %s rsp_data got %h want %h", tag, rsp_data, exp);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    vectors++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s release got valid=%b ready=%b want 0/1", tag, rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    addr = '0; wdata = '0; wr = '0;
    for (int i = 0; i < 64; i++) model[i] = '0;
    #1;
    vectors++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || rsp_data !== 32'h0 ||
        ram1 !== 32'h0 || ram2 !== 32'h0 || ram3 !== 32'h0) begin
      errors++;
      $display("FAIL reset_state got v=%b r=%b d=%h r1=%h r2=%h r3=%h want all 0",
               rsp_valid, req_ready, rsp_data, ram1, ram2, ram3);
    end
    repeat (2) @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic test_read_latency();
    int lat;
    send_req(AW'(5), 32'h0, 4'b0000, lat);
    vectors++;
    if (lat !== LAT) begin
      errors++;
      $display("FAIL read5_latency got %0d want %0d", lat, LAT);
    end
    pop_rsp("read5");
    send_req(AW'(1), 32'h0, 4'b0000, lat);
    vectors++;
    if (lat !== LAT) begin
      errors++;
      $display("FAIL read1_latency got %0d want %0d", lat, LAT);
    end
    pop_rsp("read1");
  endtask

  task automatic test_byte_write();
    int lat;
    send_req(AW'(2), 32'hDEADBEEF, 4'b1111, lat);
    pop_rsp("wr2_full");
    send_req(AW'(2), 32'h11223344, 4'b0101, lat);
    vectors++;
    if (rsp_data !== 32'hDE22BE44) begin
      errors++;
      $display("FAIL wr2_partial_rsp got %h want DE22BE44", rsp_data);
    end
    pop_rsp("wr2_partial");
    vectors++;
    if (ram2 !== 32'hDE22BE44) begin
      errors++;
      $display("FAIL ram2 got %h want DE22BE44", ram2);
    end
    send_req(AW'(1), 32'hA5A5A5A5, 4'b0010, lat);
    vectors++;
    if (ram1 !== 32'h0000A500) begin
      errors++;
      $display("FAIL ram1_lane1 got %h want 0000A500", ram1);
    end
    pop_rsp("wr1_lane1");
  endtask

  task automatic test_backpressure();
    int lat;
    logic [31:0] held;
    send_req(AW'(2), 32'h0, 4'b0000, lat);
    held = rsp_data;
    // Requests offered while busy must be ignored.
    req_valid = 1'b1; addr = AW'(2); wdata = 32'hFFFFFFFF; wr = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_data !== held || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d got v=%b d=%h r=%b want 1/%h/0",
                 c, rsp_valid, rsp_data, req_ready, held);
      end
    end
    req_valid = 1'b0; wr = 4'b0000;
    pop_rsp("backpressure");
    vectors++;
    if (ram2 !== model[2]) begin
      errors++;
      $display("FAIL ignored_req_ram2 got %h want %h", ram2, model[2]);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [AW-1:0] a;
    logic [31:0]   d;
    logic [3:0]    be;
    for (int n = 0; n < 10; n++) begin
      a  = (n < 4) ? AW'(n) : AW'($urandom);
      d  = $urandom;
      be = 4'($urandom);
      send_req(a, d, be, lat);
      vectors++;
      if (lat !== LAT) begin
        errors++;
        $display("FAIL b2b%0d_latency got %0d want %0d", n, lat, LAT);
      end
      vectors++;
      if (ram1 !== model[1] || ram2 !== model[2] || ram3 !== model[3]) begin
        errors++;
        $display("FAIL b2b%0d_taps got %h %h %h want %h %h %h",
                 n, ram1, ram2, ram3, model[1], model[2], model[3]);
      end
      pop_rsp("b2b");
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    @(negedge clk);
    req_valid = 1'b1; addr = AW'(3); wdata = 32'hCAFEF00D; wr = 4'b1111;
    @(posedge clk);
    #1;
    req_valid = 1'b0; wr = 4'b0000;
    @(negedge clk);
    vectors++;
    if (ram3 !== 32'hCAFEF00D || rsp_valid !== (LAT == 1)) begin
      errors++;
      $display("FAIL pre_abort got ram3=%h v=%b want CAFEF00D/%b", ram3, rsp_valid, LAT == 1);
    end
    nrst = 1'b0;
    #1;
    for (int i = 0; i < 64; i++) model[i] = '0;
    vectors++;
    if (rsp_valid !== 1'b0 || ram3 !== 32'h0 || req_ready !== 1'b0 || rsp_data !== 32'h0) begin
      errors++;
      $display("FAIL abort got v=%b ram3=%h r=%b d=%h want 0", rsp_valid, ram3, req_ready, rsp_data);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_hold got v=%b want 0", rsp_valid);
    end
    nrst = 1'b1;
    send_req(AW'(3), 32'h0, 4'b0000, lat);
    vectors++;
    if (lat !== LAT) begin
      errors++;
      $display("FAIL post_reset_latency got %0d want %0d", lat, LAT);
    end
    pop_rsp("post_reset_read3");
  endtask

  initial begin
    test_reset();
    test_read_latency();
    test_byte_write();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
